keypad_frontend: RTL

KEYPAD_FRONTEND -- requirements
Module: keypad_frontend

---
 rtl/kappa3_pkg.sv | 26 ++
 rtl/key_sync.sv | 27 ++
 rtl/keypad_frontend.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kappa3_pkg.sv
// Shared types, parameter limits and helpers for the keypad front end.
package kappa3_pkg;

  typedef enum logic [1:0] {
    KBD_IDLE,
    KBD_DEBOUNCE,
    KBD_HELD,
    KBD_RELEASE
  } kbd_state_t;

  localparam int DIGITS_MIN      = 1;
  localparam int DIGITS_MAX      = 16;
  localparam int DB_CYCLES_MIN   = 1;
  localparam int DB_CYCLES_MAX   = 255;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Lowest set index wins when several keys are down together.
  function automatic logic [3:0] lowest_set(input logic [15:0] keys);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (keys[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/key_sync.sv
// Multi-stage flop synchroniser for asynchronous button levels.
module key_sync
  import kappa3_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/keypad_frontend.sv
// Hex keypad front end: synchronise, debounce one shared key path, and
// assemble accepted digits into a shift buffer with clear and backspace.
module keypad_frontend
  import kappa3_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [15:0]                  keys_raw,
  input  logic                         clear_raw,
  input  logic                         bksp_raw,
  output logic [4*DIGITS-1:0]          value,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits,
  output logic                         key_event,
  output logic [3:0]                   key_code,
  output logic                         overflow
);

  localparam int              NW      = $clog2(DIGITS+1);
  localparam logic [7:0]      DB_LAST = 8'(DB_CYCLES - 1);
  localparam bit              DB_ONE  = (DB_CYCLES == 1);
  localparam logic [NW-1:0]   FULL    = NW'(DIGITS);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("keypad_frontend: DIGITS out of range");
  end
  if (DB_CYCLES < DB_CYCLES_MIN || DB_CYCLES > DB_CYCLES_MAX) begin : g_bad_db
    $error("keypad_frontend: DB_CYCLES out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("keypad_frontend: SYNC_STAGES out of range");
  end

  logic [15:0]   keys;
  logic          clear_s, bksp_s, clear_prev, bksp_prev;
  logic          pressed, commit;
  logic [3:0]    code_now, code, code_next;
  logic [7:0]    cnt, cnt_next;
  kbd_state_t    state, state_next;
  logic [4*DIGITS-1:0] value_shift;

  key_sync #(.STAGES(SYNC_STAGES), .W(16)) u_sync_keys  (.clock(clock), .reset(reset), .d(keys_raw),  .q(keys));
  key_sync #(.STAGES(SYNC_STAGES), .W(1))  u_sync_clear (.clock(clock), .reset(reset), .d(clear_raw), .q(clear_s));
  key_sync #(.STAGES(SYNC_STAGES), .W(1))  u_sync_bksp  (.clock(clock), .reset(reset), .d(bksp_raw),  .q(bksp_s));

  assign pressed  = |keys;
  assign code_now = lowest_set(keys);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= KBD_IDLE;
      cnt   <= '0;
      code  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      code  <= code_next;
    end
  end

  // cnt counts stable samples, including the one that caused the transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code;
    case (state)
      KBD_IDLE: begin
        if (pressed) begin
          code_next  = code_now;
          cnt_next   = 8'd1;
          state_next = DB_ONE ? KBD_HELD : KBD_DEBOUNCE;
        end
      end
      KBD_DEBOUNCE: begin
        if (pressed && code_now == code) begin
          cnt_next = cnt + 8'd1;
          if (cnt == DB_LAST) state_next = KBD_HELD;
        end else begin
          cnt_next   = '0;
          state_next = KBD_IDLE;
        end
      end
      KBD_HELD: begin
        if (!pressed) begin
          cnt_next   = DB_ONE ? 8'd0 : 8'd1;
          state_next = DB_ONE ? KBD_IDLE : KBD_RELEASE;
        end
      end
      KBD_RELEASE: begin
        if (pressed) begin
          cnt_next   = '0;
          state_next = KBD_HELD;
        end else if (cnt == DB_LAST) begin
          cnt_next   = '0;
          state_next = KBD_IDLE;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = KBD_IDLE;
    endcase
  end

  always_comb begin
    commit = 1'b0;
    if (state == KBD_IDLE && pressed && DB_ONE) commit = 1'b1;
    if (state == KBD_DEBOUNCE && pressed && code_now == code && cnt == DB_LAST) commit = 1'b1;
  end

  always_comb begin
    value_shift      = value << 4;
    value_shift[3:0] = code_now;
  end

  // Clear beats commit beats backspace; a commit that loses still pulses key_event.
  always_ff @(posedge clock) begin
    if (reset) begin
      value      <= '0;
      ndigits    <= '0;
      key_event  <= 1'b0;
      key_code   <= '0;
      overflow   <= 1'b0;
      clear_prev <= 1'b0;
      bksp_prev  <= 1'b0;
    end else begin
      clear_prev <= clear_s;
      bksp_prev  <= bksp_s;
      key_event  <= commit;
      if (commit) key_code <= code_now;
      if (clear_s && !clear_prev) begin
        value    <= '0;
        ndigits  <= '0;
        overflow <= 1'b0;
      end else if (commit) begin
        value <= value_shift;
        if (ndigits == FULL) begin
          if (value[4*DIGITS-1 -: 4] != 4'd0) overflow <= 1'b1;
        end else begin
          ndigits <= ndigits + 1'b1;
        end
      end else if (bksp_s && !bksp_prev) begin
        value <= value >> 4;
        if (ndigits != '0) ndigits <= ndigits - 1'b1;
      end
    end
  end

endmodule
